button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 128 ++++++++++++
 tb/tb_button_conditioner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner
// Synchronizes, debounces and edge-detects push-button inputs, with auto-repeat
// strobes on selected bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
   parameter int               N_BTN        = 10,
   parameter int               TICK_DIV     = 100000,
   parameter int               DB_TICKS     = 10,
   parameter int               REPEAT_DELAY = 500,
   parameter int               REPEAT_RATE  = 100,
   parameter logic [N_BTN-1:0] REPEAT_MASK  = 10'b0000001100
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse,
   output logic             tick
);

   localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DB_W     = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DB_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

   logic [TICK_W-1:0] tick_cnt;
   logic [N_BTN-1:0]  sync_meta;
   logic [N_BTN-1:0]  sync_q;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= btn_raw;
         sync_q    <= sync_meta;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_bit
      logic [DB_W-1:0] db_cnt;
      logic            level_q;
      logic            pulse_q;
      logic            settle;
      logic            rise;
      logic            fall;
      logic            repeat_hit;

      // Level changes only on the tick that completes DB_TICKS stable samples.
      assign settle = tick && (sync_q[i] != level_q) && (db_cnt == DB_LAST);
      assign rise   = settle && !level_q;
      assign fall   = settle && level_q;

      always_ff @(posedge clk_100MHz) begin
         if (reset) begin
            db_cnt  <= '0;
            level_q <= 1'b0;
         end else if (sync_q[i] == level_q) begin
            db_cnt <= '0;
         end else if (tick) begin
            if (db_cnt == DB_LAST) begin
               level_q <= sync_q[i];
               db_cnt  <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end

      if (REPEAT_MASK[i]) begin : g_repeat
         logic [HOLD_W-1:0] hold_cnt;

         // Reloading below REPEAT_DELAY keeps the count bounded for any hold length.
         always_ff @(posedge clk_100MHz) begin
            if (reset) begin
               hold_cnt <= '0;
            end else if (rise || fall) begin
               hold_cnt <= '0;
            end else if (level_q && tick) begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= HOLD_RELOAD;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         end

         assign repeat_hit = level_q && tick && !fall && (hold_cnt == HOLD_LAST);
      end else begin : g_no_repeat
         assign repeat_hit = 1'b0;
      end

      always_ff @(posedge clk_100MHz) begin
         if (reset) begin
            pulse_q <= 1'b0;
         end else begin
            pulse_q <= rise || repeat_hit;
         end
      end

      assign btn_level[i] = level_q;
      assign btn_pulse[i] = pulse_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: scoreboard of expected pulse cycles checked
// every cycle, plus inline level/tick checks per scenario.
`timescale 1ns/1ps
`default_nettype none

module tb_button_conditioner;

   localparam int N   = 10;
   localparam int TD  = 4;
   localparam int DB  = 3;
   localparam int RD  = 5;
   localparam int RR  = 2;
   // Input changed in a tick cycle k: sync ready by k+2, DB ticks later the level
   // toggles on the edge ending tick cycle k+TD*DB, so it is visible in cycle k+TD*DB+1.
   localparam int LAT       = TD * DB + 1;
   localparam int FIRST_REP = TD * RD;
   localparam int NEXT_REP  = TD * RR;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] btn_raw = '0;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_pulse;
   logic         tick;

   button_conditioner #(
      .N_BTN       (N),
      .TICK_DIV    (TD),
      .DB_TICKS    (DB),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR),
      .REPEAT_MASK (10'b0000001100)
   ) dut (
      .clk_100MHz(clk),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      logic [N-1:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (btn_pulse !== mon_e.val) begin
               n_err++;
               $display("FAIL pulse_expected cyc=%0d: got %b want %b", cyc, btn_pulse, mon_e.val);
            end
         end else begin
            n_vec++;
            if (btn_pulse !== '0) begin
               n_err++;
               $display("FAIL pulse_unexpected cyc=%0d: got %b want %b", cyc, btn_pulse, {N{1'b0}});
            end
         end
      end
   end

   task automatic push_exp(input int c, input logic [N-1:0] v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_tick(output int k);
      int n = 0;
      @(negedge clk);
      while (tick !== 1'b1 && n < 3 * TD) begin
         @(negedge clk);
         n++;
      end
      if (tick !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL tick_timeout cyc=%0d: got %b want 1", cyc, tick);
      end
      k = cyc;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if (btn_level !== '0) begin n_err++; $display("FAIL reset_level: got %b want 0", btn_level); end
      n_vec++;
      if (btn_pulse !== '0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", btn_pulse); end
      n_vec++;
      if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick); end
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_clean_press();
      int k, t0, m;
      wait_tick(k);
      btn_raw[0] = 1'b1;
      t0 = k + LAT;
      push_exp(t0, N'(1));
      wait_cyc(t0 - 1);
      n_vec++;
      if (btn_level[0] !== 1'b0) begin n_err++; $display("FAIL press_level_before: got %b want 0", btn_level[0]); end
      n_vec++;
      if (tick !== 1'b1) begin n_err++; $display("FAIL press_tick_before: got %b want 1", tick); end
      wait_cyc(t0);
      n_vec++;
      if (btn_level[0] !== 1'b1) begin n_err++; $display("FAIL press_level_rise: got %b want 1", btn_level[0]); end
      wait_cyc(t0 + 100);
      wait_tick(m);
      btn_raw[0] = 1'b0;
      wait_cyc(m + LAT - 1);
      n_vec++;
      if (btn_level[0] !== 1'b1) begin n_err++; $display("FAIL press_level_held: got %b want 1", btn_level[0]); end
      wait_cyc(m + LAT);
      n_vec++;
      if (btn_level[0] !== 1'b0) begin n_err++; $display("FAIL press_level_fall: got %b want 0", btn_level[0]); end
      repeat (4) @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL press_sb_left: got %0d want 0", sb.size()); end
   endtask

   task automatic test_bounce();
      int k, t0, m;
      wait_tick(k);
      btn_raw[1] = 1'b1;
      wait_cyc(k + 6);
      btn_raw[1] = 1'b0;
      wait_cyc(k + 8);
      btn_raw[1] = 1'b1;
      t0 = k + 8 + LAT;
      push_exp(t0, N'(2));
      wait_cyc(t0 - 1);
      n_vec++;
      if (btn_level[1] !== 1'b0) begin n_err++; $display("FAIL bounce_level_before: got %b want 0", btn_level[1]); end
      wait_cyc(t0);
      n_vec++;
      if (btn_level[1] !== 1'b1) begin n_err++; $display("FAIL bounce_level_rise: got %b want 1", btn_level[1]); end
      wait_cyc(t0 + 12);
      wait_tick(m);
      btn_raw[1] = 1'b0;
      wait_cyc(m + LAT);
      n_vec++;
      if (btn_level[1] !== 1'b0) begin n_err++; $display("FAIL bounce_level_fall: got %b want 0", btn_level[1]); end
      repeat (4) @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL bounce_sb_left: got %0d want 0", sb.size()); end
   endtask

   task automatic test_glitch();
      int k;
      wait_tick(k);
      btn_raw[4] = 1'b1;
      wait_cyc(k + TD * (DB - 1));
      btn_raw[4] = 1'b0;
      wait_cyc(k + LAT + TD);
      n_vec++;
      if (btn_level[4] !== 1'b0) begin n_err++; $display("FAIL glitch_level: got %b want 0", btn_level[4]); end
   endtask

   task automatic test_repeat();
      int k, t0;
      wait_tick(k);
      btn_raw[2] = 1'b1;
      t0 = k + LAT;
      push_exp(t0, N'(4));
      for (int c = t0 + FIRST_REP; c < t0 + 60; c += NEXT_REP) push_exp(c, N'(4));
      wait_cyc(t0 + 47);
      n_vec++;
      if (tick !== 1'b1) begin n_err++; $display("FAIL repeat_release_tick: got %b want 1", tick); end
      btn_raw[2] = 1'b0;
      wait_cyc(t0 + 59);
      n_vec++;
      if (btn_level[2] !== 1'b1) begin n_err++; $display("FAIL repeat_level_held: got %b want 1", btn_level[2]); end
      wait_cyc(t0 + 60);
      n_vec++;
      if (btn_level[2] !== 1'b0) begin n_err++; $display("FAIL repeat_level_fall: got %b want 0", btn_level[2]); end
      wait_cyc(t0 + 76);
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL repeat_sb_left: got %0d want 0", sb.size()); end
   endtask

   task automatic test_simultaneous();
      int k, t0, m;
      wait_tick(k);
      btn_raw[1:0] = 2'b11;
      t0 = k + LAT;
      push_exp(t0, N'(3));
      wait_cyc(t0 + 8);
      wait_tick(m);
      btn_raw[1:0] = 2'b00;
      wait_cyc(m + LAT - 1);
      n_vec++;
      if (btn_level[1:0] !== 2'b11) begin n_err++; $display("FAIL simul_level_held: got %b want 11", btn_level[1:0]); end
      wait_cyc(m + LAT);
      n_vec++;
      if (btn_level[1:0] !== 2'b00) begin n_err++; $display("FAIL simul_level_fall: got %b want 00", btn_level[1:0]); end
      repeat (4) @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL simul_sb_left: got %0d want 0", sb.size()); end
   endtask

   task automatic test_reset_mid_repeat();
      int k, t0, r, t1, m;
      wait_tick(k);
      btn_raw[3] = 1'b1;
      t0 = k + LAT;
      push_exp(t0, N'(8));
      push_exp(t0 + FIRST_REP, N'(8));
      wait_cyc(t0 + 24);
      reset = 1'b1;
      @(negedge clk);
      r = cyc;
      n_vec++;
      if (btn_level !== '0) begin n_err++; $display("FAIL midrst_level: got %b want 0", btn_level); end
      n_vec++;
      if (btn_pulse !== '0) begin n_err++; $display("FAIL midrst_pulse: got %b want 0", btn_pulse); end
      n_vec++;
      if (tick !== 1'b0) begin n_err++; $display("FAIL midrst_tick: got %b want 0", tick); end
      reset = 1'b0;
      // Counter restarts at 0 in cycle r: sync valid at r+2, ticks at r+3, r+7, r+11.
      t1 = r + 12;
      m  = t1 + 35;
      push_exp(t1, N'(8));
      for (int c = t1 + FIRST_REP; c < m + LAT; c += NEXT_REP) push_exp(c, N'(8));
      wait_cyc(t1 - 1);
      n_vec++;
      if (btn_level[3] !== 1'b0) begin n_err++; $display("FAIL midrst_level_before: got %b want 0", btn_level[3]); end
      wait_cyc(t1);
      n_vec++;
      if (btn_level[3] !== 1'b1) begin n_err++; $display("FAIL midrst_level_rise: got %b want 1", btn_level[3]); end
      wait_cyc(m);
      n_vec++;
      if (tick !== 1'b1) begin n_err++; $display("FAIL midrst_release_tick: got %b want 1", tick); end
      btn_raw[3] = 1'b0;
      wait_cyc(m + LAT);
      n_vec++;
      if (btn_level[3] !== 1'b0) begin n_err++; $display("FAIL midrst_level_fall: got %b want 0", btn_level[3]); end
      repeat (12) @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL midrst_sb_left: got %0d want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_repeat();
      test_simultaneous();
      test_reset_mid_repeat();
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
